// File: rtl/filtered_data_uart_tx_if.sv
// Stream handshake between the filter output port and the UART sink.
// A word transfers on a rising edge where input_a_stb and input_a_ack are both high.
interface filtered_data_uart_tx_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack
    );
endinterface

// File: rtl/filtered_data_uart_tx.sv
// UART 8N1 sink for 32-bit filtered samples: optional sync byte, then the word MSB byte first.
// Every output is registered; the accepted word is held until the last stop bit completes.
//
// state | meaning
// IDLE  | ack high, waiting for a strobe; line idle high
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); then next byte or back to IDLE
module filtered_data_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned SYNC_EN      = 1,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    filtered_data_uart_tx_if.slave  src,
    output logic                    o_uart_tx,
    output logic                    o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       SYNC_OFS  = (SYNC_EN != 0) ? 3'd1 : 3'd0;
    localparam logic [2:0]       LAST_BYTE = 3'd3 + SYNC_OFS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [31:0]      word;
    logic             tx_q;
    logic             ack_q;
    logic             busy_q;

    logic [2:0]       data_idx;
    logic [7:0]       cur_byte;
    logic             bit_done;

    // Byte selection is combinational from the held word, so the serialiser needs no shifter.
    always_comb begin
        data_idx = byte_idx - SYNC_OFS;
        cur_byte = word[31:24];
        if ((SYNC_OFS != 3'd0) && (byte_idx == 3'd0)) begin
            cur_byte = SYNC_BYTE;
        end else begin
            case (data_idx)
                3'd1:    cur_byte = word[23:16];
                3'd2:    cur_byte = word[15:8];
                3'd3:    cur_byte = word[7:0];
                default: cur_byte = word[31:24];
            endcase
        end
    end

    assign bit_done = (baud_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            word     <= 32'd0;
            tx_q     <= 1'b1;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (src.input_a_stb && ack_q) begin
                        word     <= src.input_a;
                        ack_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        byte_idx <= 3'd0;
                        bit_idx  <= 3'd0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end

                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        tx_q     <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            busy_q <= 1'b0;
                            ack_q  <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit directly, no gap.
                            byte_idx <= byte_idx + 3'd1;
                            tx_q     <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign src.input_a_ack = ack_q;
    assign o_uart_tx       = tx_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_filtered_data_uart_tx.sv
// Directed bench: instance A (4 clk/bit, sync byte on), instance B (2 clk/bit, no sync byte).
// Line waveforms are compared cycle by cycle against a bench-side frame model; a UART monitor decodes bytes.
module tb_filtered_data_uart_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filtered_data_uart_tx_if ifa ();
    filtered_data_uart_tx_if ifb ();

    logic tx_a, busy_a, tx_b, busy_b;

    filtered_data_uart_tx #(.CLKS_PER_BIT(CPB_A), .SYNC_EN(1), .SYNC_BYTE(8'hA5)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .src       (ifa),
        .o_uart_tx (tx_a),
        .o_busy    (busy_a)
    );

    filtered_data_uart_tx #(.CLKS_PER_BIT(CPB_B), .SYNC_EN(0), .SYNC_BYTE(8'hA5)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .src       (ifb),
        .o_uart_tx (tx_b),
        .o_busy    (busy_b)
    );

    int checks = 0;
    int errors = 0;

    // Decoded bytes; bit 8 set marks a framing error (stop bit sampled low).
    logic [8:0] rx_a[$];
    logic [8:0] rx_b[$];

    bit         mon_a_on = 1'b0;
    int         mon_a_cnt;
    logic [7:0] mon_a_byte;
    bit         mon_b_on = 1'b0;
    int         mon_b_cnt;
    logic [7:0] mon_b_byte;

    always @(negedge clk) begin
        if (rst) begin
            mon_a_on = 1'b0;
        end else if (!mon_a_on) begin
            if (tx_a === 1'b0) begin
                mon_a_on  = 1'b1;
                mon_a_cnt = 0;
            end
        end else begin
            mon_a_cnt++;
            if ((mon_a_cnt % CPB_A) == CPB_A / 2 && mon_a_cnt > CPB_A && mon_a_cnt < 9 * CPB_A) begin
                mon_a_byte[3'(mon_a_cnt / CPB_A - 1)] = tx_a;
            end else if (mon_a_cnt == 9 * CPB_A + CPB_A / 2) begin
                rx_a.push_back({~tx_a, mon_a_byte});
                mon_a_on = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            mon_b_on = 1'b0;
        end else if (!mon_b_on) begin
            if (tx_b === 1'b0) begin
                mon_b_on  = 1'b1;
                mon_b_cnt = 0;
            end
        end else begin
            mon_b_cnt++;
            if ((mon_b_cnt % CPB_B) == CPB_B / 2 && mon_b_cnt > CPB_B && mon_b_cnt < 9 * CPB_B) begin
                mon_b_byte[3'(mon_b_cnt / CPB_B - 1)] = tx_b;
            end else if (mon_b_cnt == 9 * CPB_B + CPB_B / 2) begin
                rx_b.push_back({~tx_b, mon_b_byte});
                mon_b_on = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int idx, input int sync);
        int          d;
        logic [31:0] sh;
        if (sync != 0 && idx == 0) return 8'hA5;
        d  = idx - sync;
        sh = w >> (24 - 8 * d);
        return sh[7:0];
    endfunction

    function automatic logic exp_tx(input logic [31:0] w, input int t, input int cpb, input int sync);
        int         pos;
        logic [7:0] by;
        by  = exp_byte(w, t / (10 * cpb), sync);
        pos = (t % (10 * cpb)) / cpb;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[3'(pos - 1)];
    endfunction

    // Present a word and hold stb until ack is seen; returns at the negedge right after the accepting edge.
    task automatic send(input bit use_b, input logic [31:0] w, input string tag);
        int n;
        if (use_b) begin ifb.input_a = w; ifb.input_a_stb = 1'b1; end
        else       begin ifa.input_a = w; ifa.input_a_stb = 1'b1; end
        n = 0;
        while (((use_b ? ifb.input_a_ack : ifa.input_a_ack) !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(use_b ? ifb.input_a_ack : ifa.input_a_ack), 32'd1);
        @(negedge clk);
    endtask

    // Starts on the first cycle after acceptance; ends on the cycle after the last stop bit.
    task automatic run_frame(input bit use_b, input logic [31:0] w, input string tag);
        int   cpb, sync, total, tx_err, busy_err;
        logic obs_tx, obs_busy;
        cpb      = use_b ? CPB_B : CPB_A;
        sync     = use_b ? 0 : 1;
        total    = (4 + sync) * 10 * cpb;
        tx_err   = 0;
        busy_err = 0;
        for (int t = 0; t < total; t++) begin
            obs_tx   = use_b ? tx_b : tx_a;
            obs_busy = use_b ? busy_b : busy_a;
            if (obs_tx !== exp_tx(w, t, cpb, sync)) tx_err++;
            if (obs_busy !== 1'b1) busy_err++;
            @(negedge clk);
        end
        chk({tag, "_wave_errs"}, 32'(tx_err), 32'd0);
        chk({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
        chk({tag, "_end_ack"},  32'(use_b ? ifb.input_a_ack : ifa.input_a_ack), 32'd1);
        chk({tag, "_end_busy"}, 32'(use_b ? busy_b : busy_a), 32'd0);
        chk({tag, "_end_tx"},   32'(use_b ? tx_b : tx_a), 32'd1);
    endtask

    task automatic check_rx(input bit use_b, input logic [31:0] words[$], input string tag);
        logic [8:0] got[$];
        logic [8:0] expq[$];
        int         sync, n;
        #1;
        sync = use_b ? 0 : 1;
        if (use_b) got = rx_b; else got = rx_a;
        foreach (words[k]) begin
            for (int b = 0; b < 4 + sync; b++) expq.push_back({1'b0, exp_byte(words[k], b, sync)});
        end
        chk({tag, "_rx_count"}, 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_rx_byte%0d", tag, i), 32'(got[i]), 32'(expq[i]));
        end
        if (use_b) rx_b.delete(); else rx_a.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wq[$];
        logic [31:0] exp_w[$];
        int          hs, acc, n;
        logic        prev_busy, s;

        rst = 1'b1;
        ifa.input_a = 32'd0; ifa.input_a_stb = 1'b0;
        ifb.input_a = 32'd0; ifb.input_a_stb = 1'b0;

        // 1: reset values, then ack the cycle after release
        repeat (3) @(negedge clk);
        chk("t1_rst_tx",    32'(tx_a), 32'd1);
        chk("t1_rst_ack",   32'(ifa.input_a_ack), 32'd0);
        chk("t1_rst_busy",  32'(busy_a), 32'd0);
        chk("t1_rst_ack_b", 32'(ifb.input_a_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_rel_ack",   32'(ifa.input_a_ack), 32'd1);
        chk("t1_rel_ack_b", 32'(ifb.input_a_ack), 32'd1);
        chk("t1_rel_busy",  32'(busy_a), 32'd0);
        @(negedge clk);
        chk("t1_idle_tx",   32'(tx_a), 32'd1);
        chk("t1_idle_ack",  32'(ifa.input_a_ack), 32'd1);

        // 2: single word with sync byte, 4 clocks per bit
        send(1'b0, 32'h12345678, "t2");
        ifa.input_a_stb = 1'b0;
        ifa.input_a     = 32'hFFFFFFFF;
        run_frame(1'b0, 32'h12345678, "t2");
        wq.delete(); wq.push_back(32'h12345678);
        check_rx(1'b0, wq, "t2");

        // 3: back-to-back words, data changed while the first frame is on the line
        send(1'b0, 32'hFFFF8000, "t3a");
        ifa.input_a = 32'h00000001;
        run_frame(1'b0, 32'hFFFF8000, "t3a");
        @(negedge clk);
        ifa.input_a_stb = 1'b0;
        run_frame(1'b0, 32'h00000001, "t3b");
        wq.delete(); wq.push_back(32'hFFFF8000); wq.push_back(32'h00000001);
        check_rx(1'b0, wq, "t3");

        // 4: no sync byte, 2 clocks per bit
        send(1'b1, 32'h80000001, "t4");
        ifb.input_a_stb = 1'b0;
        run_frame(1'b1, 32'h80000001, "t4");
        wq.delete(); wq.push_back(32'h80000001);
        check_rx(1'b1, wq, "t4");

        // 5: reset during bit 3 of byte 2, then a clean word
        send(1'b0, 32'hCAFEF00D, "t5a");
        ifa.input_a_stb = 1'b0;
        repeat (97) @(negedge clk);
        chk("t5_pre_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_tx",   32'(tx_a), 32'd1);
        chk("t5_rst_busy", 32'(busy_a), 32'd0);
        chk("t5_rst_ack",  32'(ifa.input_a_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rel_ack",  32'(ifa.input_a_ack), 32'd1);
        #1;
        rx_a.delete();
        send(1'b0, 32'hDEADBEEF, "t5b");
        ifa.input_a_stb = 1'b0;
        run_frame(1'b0, 32'hDEADBEEF, "t5b");
        wq.delete(); wq.push_back(32'hDEADBEEF);
        check_rx(1'b0, wq, "t5");

        // 6: random stb/data; acceptances must match observed handshakes exactly
        hs = 0;
        acc = 0;
        prev_busy = busy_a;
        exp_w.delete();
        for (int c = 0; c < 700; c++) begin
            if (busy_a && !prev_busy) acc++;
            prev_busy = busy_a;
            s = 1'($urandom_range(0, 1));
            ifa.input_a_stb = s;
            ifa.input_a     = $urandom;
            if (s && ifa.input_a_ack) begin
                hs++;
                exp_w.push_back(ifa.input_a);
            end
            @(negedge clk);
        end
        ifa.input_a_stb = 1'b0;
        n = 0;
        while (n < 600 && !(busy_a == 1'b0 && ifa.input_a_ack == 1'b1)) begin
            if (busy_a && !prev_busy) acc++;
            prev_busy = busy_a;
            @(negedge clk);
            n++;
        end
        chk("t6_drain", 32'({busy_a, ifa.input_a_ack}), 32'd1);
        repeat (2) @(negedge clk);
        chk("t6_accepted", 32'(acc), 32'(hs));
        check_rx(1'b0, exp_w, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
